// File: rtl/diff_accumulator.sv
// -----------------------------------------------------------------------------
// diff_accumulator
//
// Purpose:
//   Sums a frame of FRAME_LEN signed 4-bit difference samples into an ACC_W-bit
//   two's-complement accumulator. Samples arrive over a valid/ready handshake.
//   The completed frame sum is presented over a second valid/ready handshake.
//   A small three-state FSM (IDLE -> ACCUM -> HOLD) sequences each frame.
//
// Configuration macro:
//   DIFF_ACC_SAT_EN - when defined, an overflowing addition clamps the
//                     accumulator to the most positive or most negative value
//                     and sets a sticky overflow flag, reported on ovf.
//                     When undefined, additions wrap modulo 2^ACC_W and ovf is
//                     constant 0.
//
// Parameters:
//   FRAME_LEN  samples per frame (2..255)
//   ACC_W      accumulator / result width (5..16)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   level enable, sampled only at frame boundaries
//   clr        in   synchronous frame abort (highest priority)
//   diff_in    in   4-bit signed difference sample
//   in_valid   in   diff_in is valid
//   in_ready   out  block accepts diff_in this cycle (ACCUM state)
//   sum_out    out  completed frame sum, qualified by out_valid
//   out_valid  out  sum_out / ovf hold a completed frame (HOLD state)
//   out_ready  in   downstream consumes the result this cycle
//   ovf        out  sticky signed overflow for the frame, qualified by out_valid
// -----------------------------------------------------------------------------
module diff_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [3:0]       diff_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Sign-extend a 4-bit two's-complement sample to accumulator width.
    function automatic logic [ACC_W-1:0] sext4(input logic [3:0] d);
        return {{(ACC_W-4){d[3]}}, d};
    endfunction

`ifdef DIFF_ACC_SAT_EN
    // Signed overflow: both operands share a sign and the result's sign differs.
    function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                     input logic [ACC_W-1:0] b,
                                     input logic [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    // Clamp value toward the direction of the overflow (operand sign).
    function automatic logic [ACC_W-1:0] sat_val(input logic neg);
        logic [ACC_W-1:0] v;
        if (neg) begin
            v = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            v = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] ext_s;
    logic [ACC_W-1:0] add_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             in_hs_s;

    assign ext_s     = sext4(diff_in);
    assign add_s     = acc_q + ext_s;
    assign cnt_inc_s = cnt_q + CNT_ONE;
    // in_ready_q is high exactly when the FSM sits in ACCUM.
    assign in_hs_s   = in_valid && in_ready_q;

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clr) begin
            // Abort wins over any handshake in the same cycle.
            state_d = ST_IDLE;
            acc_d   = ACC_ZERO;
            cnt_d   = CNT_ZERO;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_ACCUM;
                        acc_d   = ACC_ZERO;
                        cnt_d   = CNT_ZERO;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_ACCUM: begin
                    // en is deliberately ignored here: a started frame always
                    // runs to completion.
                    if (in_hs_s) begin
`ifdef DIFF_ACC_SAT_EN
                        if (add_ovf(acc_q, ext_s, add_s)) begin
                            acc_d = sat_val(ext_s[ACC_W-1]);
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = add_s;
                        end
`else
                        acc_d = add_s;
`endif
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CNT_LAST) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        acc_d = ACC_ZERO;
                        cnt_d = CNT_ZERO;
                        ovf_d = 1'b0;
                        if (en) begin
                            state_d = ST_ACCUM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    acc_d   = ACC_ZERO;
                    cnt_d   = CNT_ZERO;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_ZERO;
            cnt_q       <= CNT_ZERO;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            // Decoded from the next state so the flags align with state_q.
            in_ready_q  <= (state_d == ST_ACCUM);
            out_valid_q <= (state_d == ST_HOLD);
        end
    end

    // The accumulator only changes on a handshake, and is frozen in HOLD, so it
    // doubles as the stable result register.
    assign sum_out   = acc_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    // Without saturation ovf_q is never set, so this is constant 0.
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_diff_accumulator.sv
// -----------------------------------------------------------------------------
// tb_diff_accumulator
//
// Directed self-checking bench for diff_accumulator with default parameters
// (FRAME_LEN=8, ACC_W=6). Expected values are hand-computed constants; the
// saturation-dependent values follow DIFF_ACC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_diff_accumulator;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] diff_in;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] sum_out;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;

    int n_total;
    int n_pass;

    diff_accumulator #(
        .FRAME_LEN(8),
        .ACC_W    (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .diff_in  (diff_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum_out  (sum_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for a single cycle (ready is high throughout ACCUM).
    task automatic feed(input logic [3:0] d);
        diff_in  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        diff_in  = 4'h0;
    endtask

    logic [3:0] vec_a [8];
    logic [5:0] exp_sat_pos;
    logic       exp_ovf_pos;
    logic [5:0] exp_sat_neg;
    logic       exp_ovf_neg;

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        diff_in   = 4'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

`ifdef DIFF_ACC_SAT_EN
        exp_sat_pos = 6'd31;
        exp_ovf_pos = 1'b1;
        exp_sat_neg = 6'b100000;
        exp_ovf_neg = 1'b1;
`else
        exp_sat_pos = 6'b111000;
        exp_ovf_pos = 1'b0;
        exp_sat_neg = 6'b000000;
        exp_ovf_neg = 1'b0;
`endif

        // ---------------- reset state ----------------
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum_out),   32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);

        step();
        rst_n = 1'b1;
        step();
        step();
        check("idle_en0_in_ready", 32'(in_ready), 32'd0);

        // ---------------- basic frame, with a stall cycle ----------------
        en        = 1'b1;
        out_ready = 1'b1;
        step();
        check("accum_in_ready", 32'(in_ready), 32'd1);

        vec_a[0] = 4'd3;  vec_a[1] = 4'd5;  vec_a[2] = 4'hE; vec_a[3] = 4'd1;
        vec_a[4] = 4'd0;  vec_a[5] = 4'd0;  vec_a[6] = 4'd0; vec_a[7] = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                // Stall: garbage data with in_valid low must be ignored.
                diff_in = 4'd7;
                step();
                check("stall_out_valid", 32'(out_valid), 32'd0);
            end
            feed(vec_a[i]);
        end
        check("a_out_valid", 32'(out_valid), 32'd1);
        check("a_sum",       32'(sum_out),   32'd7);
        check("a_ovf",       32'(ovf),       32'd0);
        check("a_in_ready",  32'(in_ready),  32'd0);
        step();
        check("a_consumed_valid", 32'(out_valid), 32'd0);
        check("a_next_in_ready",  32'(in_ready),  32'd1);

        // ---------------- +7 x 8 then back-pressure ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(4'd7);
        check("pos_out_valid", 32'(out_valid), 32'd1);
        check("pos_sum",       32'(sum_out),   32'(exp_sat_pos));
        check("pos_ovf",       32'(ovf),       32'(exp_ovf_pos));
        for (int i = 0; i < 5; i++) begin
            diff_in  = 4'd1;
            in_valid = 1'b1;
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum",       32'(sum_out),   32'(exp_sat_pos));
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid",    32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready),  32'd1);

        // ---------------- -8 x 8 ----------------
        for (int i = 0; i < 8; i++) feed(4'h8);
        check("neg_out_valid", 32'(out_valid), 32'd1);
        check("neg_sum",       32'(sum_out),   32'(exp_sat_neg));
        check("neg_ovf",       32'(ovf),       32'(exp_ovf_neg));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("neg_ovf_cleared", 32'(ovf), 32'd0);

        // ---------------- clr with the 4th handshake ----------------
        for (int i = 0; i < 3; i++) feed(4'd1);
        diff_in  = 4'd1;
        in_valid = 1'b1;
        clr      = 1'b1;
        step();
        in_valid = 1'b0;
        clr      = 1'b0;
        check("clr_in_ready",  32'(in_ready),  32'd0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_sum",       32'(sum_out),   32'd0);
        step();
        check("clr_restart_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) feed(4'd1);
        check("clr_frame_valid", 32'(out_valid), 32'd1);
        check("clr_frame_sum",   32'(sum_out),   32'd8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // ---------------- en dropped mid-frame ----------------
        for (int i = 0; i < 4; i++) feed(4'd2);
        en = 1'b0;
        for (int i = 0; i < 4; i++) feed(4'd2);
        check("en_drop_valid", 32'(out_valid), 32'd1);
        check("en_drop_sum",   32'(sum_out),   32'd16);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("en_drop_idle_in_ready", 32'(in_ready),  32'd0);
        check("en_drop_idle_valid",    32'(out_valid), 32'd0);

        // ---------------- async reset mid-HOLD ----------------
        en = 1'b1;
        step();
        for (int i = 0; i < 8; i++) feed(4'hF);
        check("m1_valid", 32'(out_valid), 32'd1);
        check("m1_sum",   32'(sum_out),   32'(6'b111000));
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",    32'(out_valid), 32'd0);
        check("async_rst_sum",      32'(sum_out),   32'd0);
        check("async_rst_in_ready", 32'(in_ready),  32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_in_ready", 32'(in_ready),  32'd0);
        check("post_rst_valid",    32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/diff_accumulator.md
DIFF_ACCUMULATOR -- requirements
Module: diff_accumulator

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of accepted difference samples summed per frame; legal range 2..255.
REQ-002 Parameter ACC_W, default 6: accumulator/result width in bits; legal range 5..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  level enable; low holds the block in IDLE between frames.
REQ-006 clr  input  1  synchronous frame abort: discards partial sum and count.
REQ-007 diff_in  input  4  difference sample from the upstream 4-bit subtractor, two's complement (-8..+7).
REQ-008 in_valid  input  1  diff_in is valid this cycle.
REQ-009 in_ready  output  1  block accepts diff_in this cycle.
REQ-010 sum_out  output  ACC_W  completed frame sum, two's complement.
REQ-011 out_valid  output  1  sum_out and ovf hold a completed frame.
REQ-012 out_ready  input  1  downstream accepts sum_out this cycle.
REQ-013 ovf  output  1  signed overflow occurred at any point in the frame; qualified by out_valid.

Function
REQ-014 States SHALL be IDLE, ACCUM and HOLD, with an internal accumulator acc[ACC_W-1:0] and a sample counter cnt of width clog2(FRAME_LEN+1).
REQ-015 IDLE: in_ready=0 and out_valid=0; go to ACCUM with acc=0, cnt=0 and sticky overflow=0 when en=1.
REQ-016 ACCUM: in_ready=1; a sample is accepted when in_valid and in_ready are both 1.
REQ-017 Each accepted sample SHALL be sign-extended from 4 to ACC_W bits and added to acc; cnt increments by 1.
REQ-018 When the accepted sample makes cnt equal FRAME_LEN, the next cycle SHALL be HOLD with out_valid=1 and sum_out equal to the final acc (one-cycle latency from the last handshake).
REQ-019 HOLD: in_ready=0; sum_out and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 HOLD with out_ready=1: the frame is consumed; next state is ACCUM if en=1, else IDLE; acc, cnt and overflow clear.
REQ-021 en deasserted mid-ACCUM: the frame in progress SHALL be completed; the IDLE check applies only at frame boundaries.
REQ-022 clr=1 in any state: next state IDLE, acc=0, cnt=0, overflow=0, out_valid=0; clr takes priority over a simultaneous input or output handshake, and that handshake is discarded.
REQ-023 Signed overflow on an addition means the operands have equal sign and the true sum is outside -2^(ACC_W-1)..2^(ACC_W-1)-1.
REQ-024 in_valid=0 during ACCUM SHALL leave acc and cnt unchanged.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE with acc=0, cnt=0, overflow=0, sum_out=0, out_valid=0, in_ready=0 and ovf=0, regardless of clk.
REQ-026 Reset during HOLD SHALL discard the pending result without handshake.
REQ-027 Leaving reset, the block stays in IDLE until the first rising edge that samples en=1.

Configuration
REQ-028 Macro DIFF_ACC_SAT_EN: when defined, an overflowing addition SHALL clamp acc to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative) and set the sticky overflow flag; ovf reports it.
REQ-029 Macro DIFF_ACC_SAT_EN: when undefined, additions SHALL wrap modulo 2^ACC_W, and ovf SHALL be constant 0.

Verification
REQ-030 Defaults; en=1; feed 3,5,-2,1,0,0,0,0 with in_valid=1 and out_ready=1 -> one cycle after the 8th handshake, out_valid=1 with sum_out=6'd7 and ovf=0.
REQ-031 Defaults with DIFF_ACC_SAT_EN defined; feed eight samples of +7 -> sum_out=6'd31 and ovf=1. Without the macro -> sum_out=6'b111000 (-8) and ovf=0.
REQ-032 Defaults with DIFF_ACC_SAT_EN defined; feed eight samples of -8 -> sum_out=6'b100000 (-32) and ovf=1.
REQ-033 Complete a frame, then hold out_ready=0 for 5 cycles -> sum_out and out_valid remain stable and in_ready=0; raising out_ready -> one handshake, then in_ready=1 the next cycle.
REQ-034 Pulse clr together with the 4th in_valid handshake -> IDLE, that sample discarded; a new 8-sample frame of all +1 -> sum_out=6'd8.
REQ-035 Drive rst_n low asynchronously mid-HOLD -> out_valid and sum_out go to 0 before the next clk edge; with en=0, the block remains in IDLE with in_ready=0.
